shift_sequencer: RTL

//  Multi-cycle shift controller for the ALU's fixed-distance shift stages (1/2/4/8/16).

---
 rtl/shift_sequencer_if.sv | 29 ++
 rtl/shift_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer_if
// Brief    : start/busy/done request bundle for the multi-cycle shift sequencer.
// Revision : 1.0
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic [1:0]         op;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, data_in, shamt, op,
        input  busy, done, result
    );

    modport slave (
        input  start, data_in, shamt, op,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Brief    : Shift/rotate applied one power-of-two stage per clock, largest first.
//            Optional macro SHIFT_SKIP_EN visits only the set bits of the amount.
// Revision : 1.0
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    shift_sequencer_if.slave  bus
);
    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;
    logic [K_W-1:0]     k_q, k_d;

    function automatic logic [WIDTH-1:0] stage_f(input logic [WIDTH-1:0] w,
                                                 input logic [1:0]       o,
                                                 input logic [K_W-1:0]   k);
        int amt;
        amt = 1 << k;
        case (o)
            2'b00:   stage_f = w << amt;
            2'b01:   stage_f = w >> amt;
            2'b10:   stage_f = $unsigned($signed(w) >>> amt);
            default: stage_f = (w << amt) | (w >> (WIDTH - amt));
        endcase
    endfunction

`ifdef SHIFT_SKIP_EN
    // Returns {found, index} of the highest set bit of v strictly below lim.
    function automatic logic [K_W:0] top_set_below(input logic [SHAMT_W-1:0] v,
                                                   input int                 lim);
        logic           found;
        logic [K_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (v[i] && (i < lim)) begin
                found = 1'b1;
                idx   = K_W'(i);
            end
        end
        return {found, idx};
    endfunction

    logic [K_W:0] w_first, w_next;
    assign w_first = top_set_below(bus.shamt, SHAMT_W);
    assign w_next  = top_set_below(shamt_q, int'(k_q));
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            op_q     <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
            op_q     <= op_d;
            k_q      <= k_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        op_d     = op_q;
        k_d      = k_q;
        case (state_q)
            S_SHIFT: begin
                if (shamt_q[k_q]) begin
                    work_d = stage_f(work_q, op_q, k_q);
                end
`ifdef SHIFT_SKIP_EN
                if (w_next[K_W]) begin
                    k_d = w_next[K_W-1:0];
                end else begin
                    state_d  = S_DONE;
                    result_d = work_d;
                end
`else
                if (k_q == '0) begin
                    state_d  = S_DONE;
                    result_d = work_d;
                end else begin
                    k_d = k_q - 1'b1;
                end
`endif
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (bus.start) begin
                    work_d  = bus.data_in;
                    shamt_d = bus.shamt;
                    op_d    = bus.op;
`ifdef SHIFT_SKIP_EN
                    if (w_first[K_W]) begin
                        k_d     = w_first[K_W-1:0];
                        state_d = S_SHIFT;
                    end else begin
                        k_d      = '0;
                        state_d  = S_DONE;
                        result_d = bus.data_in;
                    end
`else
                    k_d     = K_W'(SHAMT_W - 1);
                    state_d = S_SHIFT;
`endif
                end
            end
        endcase
    end

    assign bus.busy   = (state_q == S_SHIFT);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule
`default_nettype wire
